// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single unified memory port.
// Instruction fetch (IF) and load/store (D) share one port, with one
// transaction outstanding at a time. D normally has priority. A saturating
// streak counter forces an IF win after STARVE_MAX consecutive D grants
// taken while IF was waiting.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_gnt,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_valid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    err_stray
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       started;
    logic [3:0] streak;
    logic       arb_en;
    logic       pick_i;
    logic       pick_d;
    logic       waiting;

    // Memory accepts the held request in the cycle mem_ready is seen.
    assign if_gnt  = (state == REQ_I) && mem_ready;
    assign d_gnt   = (state == REQ_D) && mem_ready;
    assign waiting = (state == WAIT_I) || (state == WAIT_D);

    // Next state and arbitration. Arbitrate from IDLE, or back-to-back on
    // the response cycle so no bubble appears between transactions.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
        state_nxt = state;
        arb_en    = 1'b0;
        pick_i    = 1'b0;
        pick_d    = 1'b0;
        case (state)
            IDLE: arb_en = started;
            REQ_I: if (mem_ready) state_nxt = WAIT_I;
            REQ_D: if (mem_ready) state_nxt = WAIT_D;
            WAIT_I, WAIT_D: begin
                arb_en = mem_rvalid;
                if (mem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (arb_en) begin
            if (if_req && (!d_req || streak == STARVE_LIM)) begin
                pick_i    = 1'b1;
                state_nxt = REQ_I;
            end else if (d_req) begin
                pick_d    = 1'b1;
                state_nxt = REQ_D;
            end
        end
    end

    // State register, sticky run enable and the starvation streak counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state   <= IDLE;
            started <= 1'b0;
            streak  <= 4'd0;
        end else begin
            state   <= state_nxt;
            started <= started | start;
            if (d_gnt) begin
                if (!if_req)                 streak <= 4'd0;
                else if (streak != STARVE_LIM) streak <= streak + 4'd1;
            end else if (if_gnt) begin
                streak <= 4'd0;
            end
        end
    end

    // Registered memory-side request: the winner is latched here and held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (pick_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= {STRB_WIDTH{1'b0}};
        end else if (pick_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
        end else if (if_gnt || d_gnt) begin
            mem_req   <= 1'b0;
        end
    end

    // Route responses to their owner and flag responses nobody is waiting for.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            err_stray <= 1'b0;
        end else begin
            if_valid <= mem_rvalid && (state == WAIT_I);
            d_valid  <= mem_rvalid && (state == WAIT_D);
            if (mem_rvalid && state == WAIT_I) if_rdata <= mem_rdata;
            if (mem_rvalid && state == WAIT_D) d_rdata  <= mem_rdata;
            if (mem_rvalid && !waiting)        err_stray <= 1'b1;
        end
    end

endmodule
